gelu_unit: RTL and testbench
============================

# gelu_unit

Streaming integer GELU activation unit for the BERT encoder datapath. It accepts 256-bit beats of 32 signed int8 activations with per-beat quantisation scales. It applies a fixed-point sigmoid-gated GELU approximation per lane and emits requantised int8 results through a valid/ready interface. It sits beside the softmax and layernorm units, fed and drained by the encoder controller between FFN FC1 and FC2.

## Interface
Parameters: none (lane count 32, lane width 8 fixed).
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- data_in_valid  in  1  input beat valid
- data_in_ready  out  1  unit can accept a beat this cycle
- in_data  in  256  lane i = bits [8i+7:8i], signed int8 q_in
- in_scale  in  32  input scale S_in, unsigned Q16.16; sampled with beat
- out_scale  in  32  reciprocal output scale 1/S_out, unsigned Q16.16; sampled with beat
- data_out_valid  out  1  output beat valid
- data_out_ready  in  1  downstream accepts output
- out_data  out  256  lane i = bits [8i+7:8i], signed int8 q_out

## Operation
Per lane, all arithmetic signed, two's complement, widths sufficient to be lossless until noted:
- x = q_in * in_scale (41-bit signed, real value in Q.16).
- K = 27886 (0.4255 = 1.702/4 in Q.16). t = (K * x) >>> 16 (arithmetic shift, floor).
- h = clamp(32768 + t, 0, 65536) (hard sigmoid, Q.16).
- y = (x * h) >>> 16 (Q.16).
- p = y * out_scale (Q.32); q = p >>> 32 with rounding per Configuration.
- q_out = saturate(q, -128, 127).
- Scales carried with their beat through the pipeline; changing scales between beats is legal.
- Lanes independent; no cross-lane state.

## Timing
- 3-stage pipeline: S1 computes x (registers x, out_scale); S2 computes h, y; S3 requantises into out_data. Latency 3 cycles from accepted input to data_out_valid with no backpressure.
- Global advance enable en = !data_out_valid || data_out_ready. data_in_ready = en (combinational). Beat accepted when data_in_valid && data_in_ready.
- Per-stage valid bits shift when en=1; bubbles propagate as invalid stages. Throughput 1 beat/cycle with data_out_ready held high.
- When en=0, all stages, out_data and data_out_valid hold stable; out_data must not change while data_out_valid && !data_out_ready.
- Simultaneous output consume and input accept in the same cycle: both occur, no beat lost or duplicated.
- Reset (async, any time, including mid-stream): all stage valids 0, data_out_valid 0, out_data 0, pipeline registers 0; in-flight beats discarded. data_in_ready reads 1 during and after reset.
- data_in_valid ignored while rst is high.

## Configuration
- GELU_ROUND_EN defined: q = (p + 2^31) >>> 32 (round half up).
- Not defined: q = p >>> 32 (floor, truncation). All other behaviour identical.

## Test plan
- in_scale=out_scale=0x00010000, all lanes q_in=0,4,-4,-128 -> q_out 0,4,0,0 (both configs); lane mapping checked by distinct values per lane.
- Same scales, lanes q_in=1 and -1 -> with GELU_ROUND_EN: 1, 0; without: 0, -1.
- in_scale=0x00010000, out_scale=0x00040000, q_in=127 -> y=127, p*4=508 -> saturates to 127; q_in=2 -> 8.
- Stream 64 beats with data_out_ready=1 -> first output 3 cycles after first accept, then 1/cycle, order preserved, data_in_ready always 1.
- Random data_out_ready toggling (50%) -> no beat dropped/duplicated, out_data stable while stalled, data_in_ready low exactly when data_out_valid && !data_out_ready.
- Assert rst with 3 beats in flight -> data_out_valid and out_data go 0 immediately (asynchronously); first output after release comes only from beats accepted after reset.

Source files
------------

// File: rtl/gelu_if.sv
// Streaming valid/ready bundle for gelu_unit: 32 x int8 lanes in and out, with per-beat Q16.16 scales.
interface gelu_if;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [255:0] in_data;
  logic [31:0]  in_scale;
  logic [31:0]  out_scale;
  logic         data_out_valid;
  logic         data_out_ready;
  logic [255:0] out_data;

  modport slave (
    input  data_in_valid, in_data, in_scale, out_scale, data_out_ready,
    output data_in_ready, data_out_valid, out_data
  );

  modport master (
    output data_in_valid, in_data, in_scale, out_scale, data_out_ready,
    input  data_in_ready, data_out_valid, out_data
  );
endinterface

// File: rtl/gelu_unit.sv
// 32-lane int8 hard-sigmoid GELU with requantisation, 3-stage pipeline, global stall enable.
// Define GELU_ROUND_EN for round-half-up requantisation; default build truncates (floor).
module gelu_unit (
  input logic   clk,
  input logic   rst,
  gelu_if.slave s_if
);
  localparam int LANES = 32;

  logic w_en;
  logic w_acc;

  logic               r_s1_valid;
  logic [31:0]        r_s1_os;
  logic signed [40:0] r_s1_x [LANES];

  logic               r_s2_valid;
  logic [31:0]        r_s2_os;
  logic signed [41:0] r_s2_y [LANES];

  logic               r_out_valid;
  logic [255:0]       r_out_data;

  logic signed [40:0] w_x   [LANES];
  logic signed [56:0] w_sum [LANES];
  logic        [16:0] w_h   [LANES];
  logic signed [41:0] w_y   [LANES];
  logic signed [75:0] w_p   [LANES];
  logic signed [75:0] w_q   [LANES];
  logic [255:0]       w_out;

  assign w_en                = !r_out_valid || s_if.data_out_ready;
  assign w_acc               = s_if.data_in_valid && w_en;
  assign s_if.data_in_ready  = w_en;
  assign s_if.data_out_valid = r_out_valid;
  assign s_if.out_data       = r_out_data;

  // S1: x = q_in * S_in, exact in 41 bits
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_x[i] = $signed({{33{s_if.in_data[8*i+7]}}, s_if.in_data[8*i +: 8]})
             * $signed({9'd0, s_if.in_scale});
    end
  end

  // S2: hard sigmoid gate then y = x*h, both floored
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_sum[i] = ((57'sd27886 * $signed({{16{r_s1_x[i][40]}}, r_s1_x[i]})) >>> 16) + 57'sd32768;
      if (w_sum[i] < 57'sd0)
        w_h[i] = 17'd0;
      else if (w_sum[i] > 57'sd65536)
        w_h[i] = 17'd65536;
      else
        w_h[i] = w_sum[i][16:0];
      w_y[i] = 42'(($signed({{18{r_s1_x[i][40]}}, r_s1_x[i]}) * $signed({42'd0, w_h[i]})) >>> 16);
    end
  end

  // S3: requantise by 1/S_out and saturate to int8
  always_comb begin
    w_out = '0;
    for (int i = 0; i < LANES; i++) begin
      w_p[i] = $signed({{34{r_s2_y[i][41]}}, r_s2_y[i]}) * $signed({44'd0, r_s2_os});
`ifdef GELU_ROUND_EN
      w_q[i] = (w_p[i] + 76'sd2147483648) >>> 32;
`else
      w_q[i] = w_p[i] >>> 32;
`endif
      if (w_q[i] > 76'sd127)
        w_out[8*i +: 8] = 8'h7f;
      else if (w_q[i] < -76'sd128)
        w_out[8*i +: 8] = 8'h80;
      else
        w_out[8*i +: 8] = w_q[i][7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_os     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_os     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_s1_x[i] <= '0;
        r_s2_y[i] <= '0;
      end
    end else if (w_en) begin
      r_s1_valid  <= w_acc;
      r_s2_valid  <= r_s1_valid;
      r_out_valid <= r_s2_valid;
      if (w_acc) begin
        r_s1_os <= s_if.out_scale;
        for (int i = 0; i < LANES; i++) r_s1_x[i] <= w_x[i];
      end
      if (r_s1_valid) begin
        r_s2_os <= r_s1_os;
        for (int i = 0; i < LANES; i++) r_s2_y[i] <= w_y[i];
      end
      if (r_s2_valid) r_out_data <= w_out;
    end
  end
endmodule

// File: tb/tb_gelu_unit.sv
// Self-checking bench for gelu_unit: behavioural lane model, scoreboard queue, stall/reset checks.
module tb_gelu_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gelu_if u_if();
  gelu_unit dut (.clk(clk), .rst(rst), .s_if(u_if));

  int n_checks = 0;
  int n_errors = 0;
  logic [255:0] exp_q[$];
  int cyc = 0;
  bit meas = 1'b0;
  int first_acc = -1;
  int first_out = -1;
  bit prev_stall = 1'b0;
  logic [255:0] prev_data = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_lane(input logic [7:0] qin, input logic [31:0] si,
                                            input logic [31:0] so);
    logic signed [127:0] x, t, h, y, p, q;
    x = $signed(qin);
    x = x * $signed({96'd0, si});
    t = (x * 128'sd27886) >>> 16;
    h = t + 128'sd32768;
    if (h < 0) h = 0;
    else if (h > 65536) h = 65536;
    y = (x * h) >>> 16;
    p = y * $signed({96'd0, so});
`ifdef GELU_ROUND_EN
    p = p + 128'sd2147483648;
`endif
    q = p >>> 32;
    if (q > 127) return 8'h7f;
    if (q < -128) return 8'h80;
    return q[7:0];
  endfunction

  function automatic logic [255:0] model_beat(input logic [255:0] d, input logic [31:0] si,
                                              input logic [31:0] so);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = model_lane(d[8*i +: 8], si, so);
    return r;
  endfunction

  // Single compare process: protocol, stall stability and scoreboard on every cycle
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_reset", {255'd0, u_if.data_in_ready}, 256'd1);
      chk("out_valid_in_reset", {255'd0, u_if.data_out_valid}, 256'd0);
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("ready_eq_en", {255'd0, u_if.data_in_ready},
          {255'd0, (!u_if.data_out_valid || u_if.data_out_ready)});
      if (prev_stall) begin
        chk("stall_valid_hold", {255'd0, u_if.data_out_valid}, 256'd1);
        chk("stall_data_hold", u_if.out_data, prev_data);
      end
      if (u_if.data_out_valid && u_if.data_out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_output: got %h expected no beat", u_if.out_data);
        end else begin
          chk("out_data", u_if.out_data, exp_q.pop_front());
        end
        if (meas && first_out < 0) first_out = cyc;
      end
      if (u_if.data_in_valid && u_if.data_in_ready) begin
        exp_q.push_back(model_beat(u_if.in_data, u_if.in_scale, u_if.out_scale));
        if (meas && first_acc < 0) first_acc = cyc;
      end
      prev_stall = u_if.data_out_valid && !u_if.data_out_ready;
      prev_data  = u_if.out_data;
    end
  end

  task automatic send(input logic [255:0] d, input logic [31:0] si, input logic [31:0] so);
    bit acc;
    int n;
    u_if.data_in_valid = 1'b1;
    u_if.in_data       = d;
    u_if.in_scale      = si;
    u_if.out_scale     = so;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = u_if.data_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 256'd0, 256'd1);
    u_if.data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    u_if.data_out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("drain_empty", 256'(exp_q.size()), 256'd0);
  endtask

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [31:0] rand_scale();
    if ($urandom_range(0, 7) == 0) return $urandom();
    return $urandom_range(0, 32'h0004_0000);
  endfunction

  initial begin
    logic [255:0] d;
    logic [7:0] vals [8];
    bit acc;
    vals = '{8'h00, 8'h04, 8'hfc, 8'h80, 8'h01, 8'hff, 8'h02, 8'h7f};

    u_if.data_in_valid  = 1'b0;
    u_if.in_data        = '0;
    u_if.in_scale       = '0;
    u_if.out_scale      = '0;
    u_if.data_out_ready = 1'b1;

    // Hand-computed values pinning the model
    chk("model_q0",    {248'd0, model_lane(8'h00, 32'h10000, 32'h10000)}, 256'h00);
    chk("model_q4",    {248'd0, model_lane(8'h04, 32'h10000, 32'h10000)}, 256'h04);
    chk("model_qm4",   {248'd0, model_lane(8'hfc, 32'h10000, 32'h10000)}, 256'h00);
    chk("model_qm128", {248'd0, model_lane(8'h80, 32'h10000, 32'h10000)}, 256'h00);
`ifdef GELU_ROUND_EN
    chk("model_q1",    {248'd0, model_lane(8'h01, 32'h10000, 32'h10000)}, 256'h01);
    chk("model_qm1",   {248'd0, model_lane(8'hff, 32'h10000, 32'h10000)}, 256'h00);
`else
    chk("model_q1",    {248'd0, model_lane(8'h01, 32'h10000, 32'h10000)}, 256'h00);
    chk("model_qm1",   {248'd0, model_lane(8'hff, 32'h10000, 32'h10000)}, 256'hff);
`endif
    chk("model_sat127", {248'd0, model_lane(8'h7f, 32'h10000, 32'h40000)}, 256'h7f);
    chk("model_q2x4",   {248'd0, model_lane(8'h02, 32'h10000, 32'h40000)}, 256'h08);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_data", u_if.out_data, 256'd0);
    chk("reset_out_valid", {255'd0, u_if.data_out_valid}, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed: distinct values per lane, unit scales, then x4 output scale
    for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i * 7 - 110);
    for (int i = 0; i < 8; i++) d[8*i +: 8] = vals[i];
    send(d, 32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 32; i++) d[8*i +: 8] = (i % 2 == 0) ? 8'h7f : 8'h02;
    send(d, 32'h0001_0000, 32'h0004_0000);
    drain();

    // Back-to-back stream with ready held high
    meas = 1'b1;
    first_acc = -1;
    first_out = -1;
    for (int b = 0; b < 64; b++) begin
      u_if.data_in_valid = 1'b1;
      u_if.in_data   = rand_data();
      u_if.in_scale  = rand_scale();
      u_if.out_scale = rand_scale();
      @(posedge clk);
      #1;
    end
    u_if.data_in_valid = 1'b0;
    drain();
    meas = 1'b0;
    chk("first_latency", 256'(first_out - first_acc), 256'd3);

    // Random backpressure and bubbles
    for (int c = 0; c < 400; c++) begin
      u_if.data_out_ready = 1'($urandom_range(0, 1));
      if (!u_if.data_in_valid && $urandom_range(0, 3) != 0) begin
        u_if.data_in_valid = 1'b1;
        u_if.in_data   = rand_data();
        u_if.in_scale  = rand_scale();
        u_if.out_scale = rand_scale();
      end
      @(negedge clk);
      acc = u_if.data_in_valid && u_if.data_in_ready;
      @(posedge clk);
      #1;
      if (acc) u_if.data_in_valid = 1'b0;
    end
    u_if.data_in_valid = 1'b0;
    drain();

    // Async reset with three beats in flight
    u_if.data_out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      u_if.data_in_valid = 1'b1;
      u_if.in_data   = rand_data();
      u_if.in_scale  = 32'h0001_0000;
      u_if.out_scale = 32'h0001_0000;
      @(posedge clk);
      #1;
    end
    chk("pre_reset_valid", {255'd0, u_if.data_out_valid}, 256'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_valid", {255'd0, u_if.data_out_valid}, 256'd0);
    chk("async_reset_data", u_if.out_data, 256'd0);
    chk("async_reset_ready", {255'd0, u_if.data_in_ready}, 256'd1);
    u_if.in_data = {8{32'h7f7f7f7f}};
    repeat (2) @(posedge clk);
    #1;
    u_if.data_in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(rand_data(), 32'h0002_0000, 32'h0000_8000);
    send(rand_data(), 32'h0001_0000, 32'h0001_0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
    $fatal(1);
  end
endmodule
